alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle issue/writeback controller on the driving side of the combinational ALU: accepts one operation request at a time, drives the ALU operand and function-code inputs, waits the operation's latency, then captures result r, upper/remainder s and exception flag.
- Produces a register-file writeback: r goes to the destination register; s goes to R15 for MUL/DIV only.
- Sits between the decode stage and the ALU/register file in the 16-bit datapath.

Parameters:
- REG_DATA_WIDTH, 16, operand/result width
- ALU_CONTROL_WIDTH, 4, function-code width
- REG_ADDR_WIDTH, 4, register index width
- MULDIV_CYCLES, 4, EXEC cycles held for MUL/DIV (min 1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept (high only in IDLE)
- req_op  in  ALU_CONTROL_WIDTH  function code
- req_a, req_b  in  REG_DATA_WIDTH  operands
- req_rd  in  REG_ADDR_WIDTH  destination register
- alu_a, alu_b  out  REG_DATA_WIDTH  operands to ALU
- alu_control  out  ALU_CONTROL_WIDTH  function code to ALU
- alu_r, alu_s  in  REG_DATA_WIDTH  ALU low/high results
- alu_exc  in  1  ALU exception
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  REG_ADDR_WIDTH  writeback register
- wb_data  out  REG_DATA_WIDTH  captured r
- wb_s_en  out  1  write wb_s_data to R15 (MUL/DIV only)
- wb_s_data  out  REG_DATA_WIDTH  captured s
- exc_out  out  1  one-cycle exception pulse
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst high at a clk edge): state IDLE; every output and internal register 0; req_ready=1 on the cycle after reset.
- Function codes: ADD 1111, SUB 1110, AND 1101, OR 1100, MUL 0001, DIV 0010, SLL 1010, SLR 1011, ROL 1001, ROR 1000, NOP 0000.
- Handshake: transfer occurs when req_valid && req_ready at a rising edge. Operands, op and rd are latched and held stable on alu_* until CAPTURE completes.
- alu_control is 0000 (NOP) and alu_a/alu_b are 0 whenever state is IDLE.
- States:
  - IDLE -> EXEC on accept.
  - EXEC: ALU driven. Counter loads 0 on entry. Single-cycle ops stay 1 cycle; MUL/DIV stay MULDIV_CYCLES cycles. Then -> CAPTURE.
  - CAPTURE: registers alu_r, alu_s, alu_exc -> RESP.
  - RESP: exactly one of wb_valid or exc_out pulses for one cycle -> IDLE.
- Latency, single-cycle op: accept edge T; wb_valid high in cycle T+3; req_ready high again at T+4. MUL/DIV add MULDIV_CYCLES-1 cycles.
- Back-to-back: a new request is accepted only in IDLE; no overlap.
- wb_s_en=1 only for MUL/DIV with no exception; wb_s_data = s (product upper half or remainder).
- DIV with b==0: detected at accept. Go directly to RESP with exc_out=1, no wb. The ALU is never driven with zero divisor; alu_control stays NOP.
- Invalid code (0011-0111): exc_out=1, no wb. NOP (0000): wb_valid=1 with wb_data=0, wb_s_en=0.
- alu_exc=1 at CAPTURE: exc_out pulse; wb_valid, wb_s_en stay 0; destination not written.
- wb_rd = latched req_rd. wb_data/wb_s_data hold their last values after the pulse (only meaningful during the strobe).
- rst in any state: abort immediately; no wb or exc pulse is emitted for the aborted op.

Decomposition:
- Package alu_pkg holds:
  - function-code constants;
  - state encoding (IDLE, EXEC, CAPTURE, RESP);
  - is_muldiv and is_valid_op helper functions.
- Shared with the ALU so codes have one definition.
- One natural sub-module: alu_latency_counter (load/enable/done down-counter sized by $clog2(MULDIV_CYCLES+1)).

Test Plan:
- ADD a=0x0003 b=0x0004 rd=2 -> alu_control=1111 during EXEC; wb_valid at T+3, wb_rd=2, wb_data=0x0007, wb_s_en=0.
- MUL a=0x0100 b=0x0100 rd=5, MULDIV_CYCLES=4 -> wb at T+6; wb_data=0x0000, wb_s_data=0x0001, wb_s_en=1.
- DIV a=0x000A b=0x0003 -> wb_data=0x0003, wb_s_data=0x0001, wb_s_en=1. DIV b=0 -> exc_out pulse, no wb_valid, alu_control stays 0000.
- ADD a=0x7FFF b=0x0001 (ALU asserts alu_exc) -> exc_out one cycle, wb_valid=0. Op 0101 -> exc_out, no wb.
- req_valid held high with two queued ADDs -> second accepted only after RESP; req_ready low for 3 cycles between accepts.
- rst asserted mid-MUL EXEC cycle 2 -> next cycle all outputs 0, req_ready=1, no wb/exc pulse ever emitted for the aborted op.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU function codes, sequencer state encoding and op classification helpers
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0001;
  localparam logic [OP_W-1:0] OP_DIV = 4'b0010;
  localparam logic [OP_W-1:0] OP_ROR = 4'b1000;
  localparam logic [OP_W-1:0] OP_ROL = 4'b1001;
  localparam logic [OP_W-1:0] OP_SLL = 4'b1010;
  localparam logic [OP_W-1:0] OP_SLR = 4'b1011;
  localparam logic [OP_W-1:0] OP_OR  = 4'b1100;
  localparam logic [OP_W-1:0] OP_AND = 4'b1101;
  localparam logic [OP_W-1:0] OP_SUB = 4'b1110;
  localparam logic [OP_W-1:0] OP_ADD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Codes 0011..0111 are unassigned and are rejected without touching the ALU.
  function automatic logic is_valid_op(input logic [OP_W-1:0] op);
    return !((op >= 4'b0011) && (op <= 4'b0111));
  endfunction

endpackage

// File: rtl/alu_latency_counter.sv
// rtl/alu_latency_counter.sv - loadable down-counter timing how long an op stays in EXEC
module alu_latency_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issue/writeback controller driving the combinational ALU
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int REG_DATA_WIDTH    = 16,
  parameter int ALU_CONTROL_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 4,
  parameter int MULDIV_CYCLES     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ALU_CONTROL_WIDTH-1:0] req_op,
  input  logic [REG_DATA_WIDTH-1:0]    req_a,
  input  logic [REG_DATA_WIDTH-1:0]    req_b,
  input  logic [REG_ADDR_WIDTH-1:0]    req_rd,
  output logic [REG_DATA_WIDTH-1:0]    alu_a,
  output logic [REG_DATA_WIDTH-1:0]    alu_b,
  output logic [ALU_CONTROL_WIDTH-1:0] alu_control,
  input  logic [REG_DATA_WIDTH-1:0]    alu_r,
  input  logic [REG_DATA_WIDTH-1:0]    alu_s,
  input  logic                         alu_exc,
  output logic                         wb_valid,
  output logic [REG_ADDR_WIDTH-1:0]    wb_rd,
  output logic [REG_DATA_WIDTH-1:0]    wb_data,
  output logic                         wb_s_en,
  output logic [REG_DATA_WIDTH-1:0]    wb_s_data,
  output logic                         exc_out,
  output logic                         busy
);

  localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_t state, state_next;

  logic [ALU_CONTROL_WIDTH-1:0] op_q;
  logic [REG_DATA_WIDTH-1:0]    a_q, b_q, r_q, s_q;
  logic [REG_ADDR_WIDTH-1:0]    rd_q;
  logic                         exc_q, s_en_q;

  logic             accept, early_exc, cnt_done;
  logic [CNT_W-1:0] cnt_load_value;

  assign accept    = req_valid && (state == ST_IDLE);
  // Zero divisors and unassigned codes fail at accept so the ALU never sees them.
  assign early_exc = !is_valid_op(req_op) || ((req_op == OP_DIV) && (req_b == '0));
  assign cnt_load_value = is_muldiv(req_op) ? MULDIV_LOAD : '0;

  alu_latency_counter #(
    .WIDTH(CNT_W)
  ) u_latency (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_value(cnt_load_value),
    .en        (state == ST_EXEC),
    .done      (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      r_q    <= '0;
      s_q    <= '0;
      exc_q  <= 1'b0;
      s_en_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q   <= req_op;
        a_q    <= req_a;
        b_q    <= req_b;
        rd_q   <= req_rd;
        exc_q  <= early_exc;
        s_en_q <= 1'b0;
      end
      if (state == ST_CAPTURE) begin
        r_q    <= (op_q == OP_NOP) ? '0 : alu_r;
        s_q    <= alu_s;
        exc_q  <= alu_exc;
        s_en_q <= is_muldiv(op_q) && !alu_exc;
      end
    end
  end

  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = OP_NOP;
    wb_valid    = 1'b0;
    wb_s_en     = 1'b0;
    exc_out     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_next = early_exc ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_a       = a_q;
        alu_b       = b_q;
        alu_control = op_q;
        if (cnt_done) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        alu_a       = a_q;
        alu_b       = b_q;
        alu_control = op_q;
        state_next  = ST_RESP;
      end
      ST_RESP: begin
        wb_valid   = !exc_q;
        wb_s_en    = !exc_q && s_en_q;
        exc_out    = exc_q;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign wb_rd     = rd_q;
  assign wb_data   = r_q;
  assign wb_s_data = s_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed vector bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_op, req_rd, alu_control, wb_rd;
  logic [15:0] req_a, req_b, alu_a, alu_b, alu_r, alu_s, wb_data, wb_s_data;
  logic        alu_exc, wb_valid, wb_s_en, exc_out, busy;

  always #5 clk = ~clk;

  alu_sequencer #(
    .REG_DATA_WIDTH(16), .ALU_CONTROL_WIDTH(4), .REG_ADDR_WIDTH(4), .MULDIV_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_r(alu_r), .alu_s(alu_s), .alu_exc(alu_exc),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_s_en(wb_s_en),
    .wb_s_data(wb_s_data), .exc_out(exc_out), .busy(busy)
  );

  // Behavioural ALU; NOP returns junk so the sequencer's forced-zero result is visible.
  logic [31:0] prod, dbl;
  logic [15:0] rtmp;
  always_comb begin
    alu_r = '0; alu_s = '0; alu_exc = 1'b0; prod = '0; dbl = '0; rtmp = '0;
    case (alu_control)
      OP_ADD: begin
        rtmp = alu_a + alu_b; alu_r = rtmp;
        alu_exc = (alu_a[15] == alu_b[15]) && (rtmp[15] != alu_a[15]);
      end
      OP_SUB: begin
        rtmp = alu_a - alu_b; alu_r = rtmp;
        alu_exc = (alu_a[15] != alu_b[15]) && (rtmp[15] != alu_a[15]);
      end
      OP_AND: alu_r = alu_a & alu_b;
      OP_OR:  alu_r = alu_a | alu_b;
      OP_MUL: begin
        prod = 32'(alu_a) * 32'(alu_b); alu_r = prod[15:0]; alu_s = prod[31:16];
      end
      OP_DIV: if (alu_b != '0) begin alu_r = alu_a / alu_b; alu_s = alu_a % alu_b; end
      OP_SLL: alu_r = alu_a << alu_b[3:0];
      OP_SLR: alu_r = alu_a >> alu_b[3:0];
      OP_ROL: begin dbl = {alu_a, alu_a} << alu_b[3:0]; alu_r = dbl[31:16]; end
      OP_ROR: begin dbl = {alu_a, alu_a} >> alu_b[3:0]; alu_r = dbl[15:0]; end
      OP_NOP: alu_r = 16'hDEAD;
      default: alu_r = '0;
    endcase
  end

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [3:0]  rd;
    logic        exp_exc;
    int          exp_lat;
    logic [15:0] exp_data;
    logic        exp_s_en;
    logic [15:0] exp_s_data;
    logic        exp_drive;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] rd, input logic exc, input int lat,
                              input logic [15:0] d, input logic s_en, input logic [15:0] s,
                              input logic drive);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.rd = rd; v.exp_exc = exc; v.exp_lat = lat;
    v.exp_data = d; v.exp_s_en = s_en; v.exp_s_data = s; v.exp_drive = drive;
    return v;
  endfunction

  task automatic wait_strobe(output int cyc, output logic seen);
    cyc = 1; seen = 1'b0;
    while (!seen && cyc <= 30) begin
      if (wb_valid || exc_out) seen = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    logic seen;
    @(negedge clk);
    check($sformatf("v%0d_ready", idx), req_ready, 1);
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b; req_rd = v.rd;
    @(negedge clk);
    req_valid = 1'b0;
    check($sformatf("v%0d_busy", idx), busy, 1);
    check($sformatf("v%0d_alu_control", idx), alu_control, v.exp_drive ? v.op : 4'b0000);
    wait_strobe(cyc, seen);
    check($sformatf("v%0d_strobe_seen", idx), seen, 1);
    check($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
    check($sformatf("v%0d_wb_valid", idx), wb_valid, !v.exp_exc);
    check($sformatf("v%0d_exc_out", idx), exc_out, v.exp_exc);
    check($sformatf("v%0d_wb_s_en", idx), wb_s_en, v.exp_s_en);
    if (!v.exp_exc) begin
      check($sformatf("v%0d_wb_rd", idx), wb_rd, v.rd);
      check($sformatf("v%0d_wb_data", idx), wb_data, v.exp_data);
    end
    if (v.exp_s_en) check($sformatf("v%0d_wb_s_data", idx), wb_s_data, v.exp_s_data);
    @(negedge clk);
    check($sformatf("v%0d_pulse_end", idx), {wb_valid, exc_out}, 2'b00);
    check($sformatf("v%0d_ready_again", idx), req_ready, 1);
  endtask

  initial begin
    int low, cyc;
    logic seen, first_wb, bad_pulse;
    logic [15:0] first_data;
    logic [3:0] first_rd;

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_rd = '0;

    //            op      a        b        rd  exc lat data     s_en s        drive
    vecs.push_back(mk(OP_ADD, 16'h0003, 16'h0004, 4'd2, 0, 3, 16'h0007, 0, 16'h0000, 1));
    vecs.push_back(mk(OP_MUL, 16'h0100, 16'h0100, 4'd5, 0, 6, 16'h0000, 1, 16'h0001, 1));
    vecs.push_back(mk(OP_DIV, 16'h000A, 16'h0003, 4'd7, 0, 6, 16'h0003, 1, 16'h0001, 1));
    vecs.push_back(mk(OP_DIV, 16'h000A, 16'h0000, 4'd7, 1, 1, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(OP_ADD, 16'h7FFF, 16'h0001, 4'd4, 1, 3, 16'h0000, 0, 16'h0000, 1));
    vecs.push_back(mk(4'b0101, 16'h0001, 16'h0001, 4'd4, 1, 1, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(OP_SUB, 16'h0010, 16'h0003, 4'd6, 0, 3, 16'h000D, 0, 16'h0000, 1));
    vecs.push_back(mk(OP_AND, 16'hF0F0, 16'h0FF0, 4'd8, 0, 3, 16'h00F0, 0, 16'h0000, 1));
    vecs.push_back(mk(OP_OR,  16'hF000, 16'h000F, 4'd9, 0, 3, 16'hF00F, 0, 16'h0000, 1));
    vecs.push_back(mk(OP_SLL, 16'h0001, 16'h0004, 4'd1, 0, 3, 16'h0010, 0, 16'h0000, 1));
    vecs.push_back(mk(OP_SLR, 16'h8000, 16'h000F, 4'd3, 0, 3, 16'h0001, 0, 16'h0000, 1));
    vecs.push_back(mk(OP_ROL, 16'h8001, 16'h0001, 4'd10, 0, 3, 16'h0003, 0, 16'h0000, 1));
    vecs.push_back(mk(OP_ROR, 16'h0001, 16'h0001, 4'd11, 0, 3, 16'h8000, 0, 16'h0000, 1));
    vecs.push_back(mk(OP_NOP, 16'h1234, 16'h5678, 4'd12, 0, 3, 16'h0000, 0, 16'h0000, 1));
    vecs.push_back(mk(OP_MUL, 16'h1234, 16'h0010, 4'd13, 0, 6, 16'h2340, 1, 16'h0001, 1));

    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_strobes", {wb_valid, wb_s_en, exc_out}, 3'b000);
    check("rst_alu", {alu_control, alu_a, alu_b}, 36'h0);
    check("rst_wb", {wb_rd, wb_data, wb_s_data}, 36'h0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Two ADDs with req_valid held high: second waits out EXEC, CAPTURE and RESP.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADD; req_a = 16'h0001; req_b = 16'h0001; req_rd = 4'd1;
    @(negedge clk);
    req_a = 16'h0002; req_b = 16'h0002; req_rd = 4'd3;
    low = 0; first_wb = 1'b0; first_data = '0; first_rd = '0;
    while (!req_ready && low < 10) begin
      if (wb_valid) begin first_wb = 1'b1; first_data = wb_data; first_rd = wb_rd; end
      low++;
      @(negedge clk);
    end
    check("b2b_ready_low_cycles", low, 3);
    check("b2b_first_wb", first_wb, 1);
    check("b2b_first_data", first_data, 16'h0002);
    check("b2b_first_rd", first_rd, 4'd1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_strobe(cyc, seen);
    check("b2b_second_seen", seen, 1);
    check("b2b_second_latency", cyc, 3);
    check("b2b_second_data", wb_data, 16'h0004);
    check("b2b_second_rd", wb_rd, 4'd3);
    @(negedge clk);

    // Reset during the second EXEC cycle of a MUL aborts it silently.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MUL; req_a = 16'h0003; req_b = 16'h0005; req_rd = 4'd6;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_exec", alu_control, OP_MUL);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", req_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_alu", {alu_control, alu_a, alu_b}, 36'h0);
    check("abort_wb", {wb_valid, wb_s_en, exc_out, wb_rd, wb_data, wb_s_data}, 39'h0);
    rst = 1'b0;
    bad_pulse = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (wb_valid || exc_out) bad_pulse = 1'b1;
    end
    check("abort_no_pulse", bad_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
